stddev_norm: RTL and testbench

- Computes the window standard deviation used for variance normalisation of Haar feature thresholds.
- Takes the integral-image window sum and squared sum, and forms var = WIN_AREA*sq_sum - sum^2.
- Normalises var to an 8-bit mantissa, drives the shared sqrt_rom (1-cycle read), then denormalises the result into a Q.8 std value.
- Sits between the integral/square-integral window extractor and the feature evaluation stage.

---
 rtl/cascade_pkg.sv | 33 +++
 rtl/sqrt_norm.sv | 26 ++
 rtl/stddev_norm.sv | 81 ++++++++
 tb/tb_stddev_norm.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cascade_pkg.sv
// Shared widths and stage bundles for the
// window variance / std normalisation path.
package cascade_pkg;

  localparam int W_SUM    = 18;
  localparam int W_SQSUM  = 26;
  localparam int WIN_AREA = 576;
  localparam int W_VAR    = W_SQSUM + 10;
  localparam int W_STD    = W_VAR / 2 + 8;
  localparam int W_DIFF   = W_VAR + 1;
  localparam int W_P      = $clog2(W_VAR);
  localparam int W_J      = $clog2(W_VAR / 2 + 1);
  localparam int W_M      = 8;
  localparam int W_ROM    = 16;
  localparam int ROM_LAT  = 1;

  typedef struct packed {
    logic             valid;
    logic [W_VAR-1:0] variance;
  } s1_t;

  typedef struct packed {
    logic           valid;
    logic [W_J-1:0] j;
  } s2_t;

  typedef struct packed {
    logic             valid;
    logic [W_J-1:0]   j;
    logic [W_ROM-1:0] data;
  } s3_t;

endpackage

// File: rtl/sqrt_norm.sv
// Splits variance into an 8-bit mantissa and an
// even exponent index j so sqrt reduces to a ROM read.
module sqrt_norm
  import cascade_pkg::*;
(
  input  logic [W_VAR-1:0] variance,
  output logic [W_M-1:0]   m,
  output logic [W_J-1:0]   j
);

  logic [W_P-1:0] p;

  always_comb begin
    p = '0;
    for (int i = 0; i < W_VAR; i++) begin
      if (variance[i]) p = W_P'(i);
    end
  end

  // odd exponent e = 2j-7 >= p-7  <=>  j = ceil(p/2)
  assign j = W_J'((p + W_P'(1)) >> 1);

  // m = var * 2^7 / 2^(2j) == var >> e
  assign m = W_M'({variance, 7'b0} >> {j, 1'b0});

endmodule

// File: rtl/stddev_norm.sv
// Window std deviation in Q.8: variance, normalise,
// shared sqrt ROM lookup, denormalise; global stall.
module stddev_norm
  import cascade_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W_SUM-1:0]   sum,
  input  logic [W_SQSUM-1:0] sq_sum,
  output logic               rom_en,
  output logic [7:0]         rom_addr,
  input  logic [15:0]        rom_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W_STD-1:0]   std_q8
);

  localparam logic [W_J-1:0] J_UNITY = W_J'(7);

  logic              adv;
  s1_t               s1;
  s2_t               s2;
  s3_t               s3;
  logic [W_DIFF-1:0] prod;
  logic [W_DIFF-1:0] sq;
  logic [W_DIFF-1:0] diff;
  logic [W_VAR-1:0]  var_next;
  logic [W_M-1:0]    m2;
  logic [W_J-1:0]    j2;
  logic [W_STD-1:0]  std_next;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign rom_en   = adv;

  assign prod = W_DIFF'(sq_sum) * W_DIFF'(WIN_AREA);
  assign sq   = W_DIFF'(sum) * W_DIFF'(sum);
  assign diff = prod - sq;

  // both operands < 2^W_VAR, so the top bit is the sign
  assign var_next = diff[W_VAR] ? '0 : diff[W_VAR-1:0];

  sqrt_norm u_norm (
    .variance (s1.variance),
    .m        (m2),
    .j        (j2)
  );

  assign rom_addr = m2;

  always_comb begin
    std_next = W_STD'(s3.data);
    if (s3.j >= J_UNITY)
      std_next = std_next << (s3.j - J_UNITY);
    else
      std_next = std_next >> (J_UNITY - s3.j);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1        <= '0;
      s2        <= '0;
      s3        <= '0;
      out_valid <= 1'b0;
      std_q8    <= '0;
    end else if (adv) begin
      s1.valid    <= in_valid;
      s1.variance <= var_next;
      s2.valid    <= s1.valid;
      s2.j        <= j2;
      s3.valid    <= s2.valid;
      s3.j        <= s2.j;
      s3.data     <= rom_data;
      out_valid   <= s3.valid;
      std_q8      <= std_next;
    end
  end

endmodule

// File: tb/tb_stddev_norm.sv
// Bench for stddev_norm: directed vectors, stall and
// reset sequences, random traffic vs reference model.
module tb_stddev_norm;
  import cascade_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [W_SUM-1:0]   sum;
  logic [W_SQSUM-1:0] sq_sum;
  logic               rom_en;
  logic [7:0]         rom_addr;
  logic [15:0]        rom_data = '0;
  logic               out_valid;
  logic               out_ready;
  logic [W_STD-1:0]   std_q8;

  logic [W_VAR-1:0]   nv;
  logic [W_M-1:0]     nm;
  logic [W_J-1:0]     nj;

  int n_cmp = 0;
  int n_bad = 0;
  longint expq[$];

  always #5 clk = ~clk;

  stddev_norm dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .sq_sum    (sq_sum),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .std_q8    (std_q8)
  );

  sqrt_norm u_norm_chk (
    .variance (nv),
    .m        (nm),
    .j        (nj)
  );

  function automatic longint isqrt(input longint x);
    longint r = 0;
    for (int b = 20; b >= 0; b--) begin
      longint t = r | (longint'(1) << b);
      if (t * t <= x) r = t;
    end
    return r;
  endfunction

  // floor(sqrt(m*128)*256) == isqrt(m * 128 * 65536)
  function automatic longint rom_ref(input longint m);
    return isqrt(m << 23);
  endfunction

  always @(posedge clk)
    if (rom_en) rom_data <= 16'(rom_ref(longint'(rom_addr)));

  function automatic void ref_norm(input longint v,
                                   output longint m,
                                   output int j);
    int p = 0;
    int e;
    if (v == 0) begin
      m = 0;
      j = 0;
    end else begin
      for (int i = 0; i < 40; i++) if (v[i]) p = i;
      e = p - 7;
      if ((e & 1) == 0) e = e + 1;
      if (e < -7) e = -7;
      m = (e > 0) ? (v >> e) : (v << (-e));
      j = (e + 7) / 2;
    end
  endfunction

  function automatic longint ref_std(input longint s, input longint q);
    longint v, m, r;
    int j;
    v = longint'(WIN_AREA) * q - s * s;
    if (v < 0) v = 0;
    ref_norm(v, m, j);
    r = rom_ref(m);
    if (j >= 7) return r << (j - 7);
    return r >> (7 - j);
  endfunction

  task automatic check(input string name, input longint act,
                       input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      expq.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: got std %0h expected none at %0t",
                   std_q8, $time);
        end else begin
          check("sb_std", longint'(std_q8), expq.pop_front());
        end
      end
      if (in_valid && in_ready)
        expq.push_back(ref_std(longint'(sum), longint'(sq_sum)));
    end
  end

  typedef struct {
    longint s;
    longint q;
    longint addr;
    longint stdv;
  } vec_t;

  vec_t tbl[5];

  task automatic drive(input longint s, input longint q);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    sum      = W_SUM'(s);
    sq_sum   = W_SQSUM'(q);
  endtask

  task automatic send_vec(input vec_t v);
    int k = 0;
    bit got = 0;
    drive(v.s, v.q);
    @(negedge clk);
    check("accept", longint'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    while (k < 10 && !got) begin
      @(negedge clk);
      k++;
      if (k == 1) check("rom_addr", longint'(rom_addr), v.addr);
      if (out_valid) got = 1;
    end
    check("latency", k, 4);
    check("std_q8", longint'(std_q8), v.stdv);
  endtask

  task automatic drain(input string name);
    int k = 0;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (k < 60 && expq.size() != 0) begin
      @(negedge clk);
      k++;
    end
    check(name, expq.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    longint v, m, e0;
    int j, stale;

    tbl[0] = '{0, 1, 72, 64'h1800};
    tbl[1] = '{1, 1, 71, 64'h17d5};
    tbl[2] = '{24, 1, 0, 0};
    tbl[3] = '{100, 0, 0, 0};
    tbl[4] = '{0, 64'h3ffffff, 71, 64'h2faa000};

    rst       = 1'b0;
    in_valid  = 1'b0;
    sum       = '0;
    sq_sum    = '0;
    out_ready = 1'b1;
    nv        = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_std", longint'(std_q8), 0);
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_rom_addr", longint'(rom_addr), 0);
    @(posedge clk);
    #1 rst = 1'b1;

    for (int b = 0; b <= W_VAR; b++) begin
      if (b == 0) v = 0;
      else v = (longint'(1) << (b - 1)) |
               (longint'({$urandom, $urandom}) &
                ((longint'(1) << (b - 1)) - 1));
      nv = W_VAR'(v);
      #1;
      ref_norm(v, m, j);
      check("norm_m", longint'(nm), m);
      check("norm_j", longint'(nj), j);
    end

    for (int i = 0; i < 5; i++) send_vec(tbl[i]);
    drain("drain_tbl");

    e0 = ref_std(0, 1);
    drive(0, 1);
    drive(1, 1);
    drive(0, 64'h3ffffff);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", longint'(in_ready), 0);
      check("stall_out_valid", longint'(out_valid), 1);
      check("stall_std", longint'(std_q8), e0);
    end
    drain("drain_stall");

    drive(0, 1);
    drive(1, 1);
    drive(50, 5000);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", longint'(out_valid), 0);
    check("mid_rst_std", longint'(std_q8), 0);
    check("mid_rst_in_ready", longint'(in_ready), 1);
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("no_stale", stale, 0);

    for (int c = 0; c < 500; c++) begin
      longint s, q;
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0: begin
          s = longint'($urandom_range(0, (1 << W_SUM) - 1));
          q = longint'($urandom_range(0, (1 << W_SQSUM) - 1));
        end
        1: begin
          s = longint'($urandom_range(0, 146880));
          q = s * s / 576 + longint'($urandom_range(0, 100000));
          if (q > 64'h3ffffff) q = 64'h3ffffff;
        end
        2: begin
          s = longint'($urandom_range(0, 300));
          q = longint'($urandom_range(0, 2000));
        end
        default: begin
          s = 0;
          q = longint'($urandom_range(0, (1 << W_SQSUM) - 1));
        end
      endcase
      sum    = W_SUM'(s);
      sq_sum = W_SQSUM'(q);
    end
    drain("drain_rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
